// File: rtl/multi_down_timer.sv
// -----------------------------------------------------------------------------
// multi_down_timer
//   CHANNELS independent N-bit down-timers driven by one shared prescaled tick.
//   Each channel is loaded with a value V and expires on the (V+1)th tick after
//   the load. A channel is either one-shot (stops in DONE) or periodic (reloads
//   V and keeps running). Expiry sets a sticky done flag and emits a one-cycle
//   expire pulse. stop aborts a channel; ack clears its done flag.
//
// Parameters
//   N        counter / load width per channel
//   CHANNELS number of channels (1..16)
//   PRESCALE en cycles per timer tick (1..65535)
//
// Ports
//   clk          system clock
//   reset        asynchronous active-high reset
//   en           global count enable into the prescaler
//   ld           load strobe for channel ld_ch (ignored if ld_ch >= CHANNELS)
//   ld_ch        target channel of the load
//   ld_periodic  mode captured on load: 1 periodic, 0 one-shot
//   data_in      load / reload value
//   stop         per-channel abort
//   ack          per-channel done clear
//   busy         channel is running (registered)
//   done         sticky expiry flag (registered)
//   expire       one-cycle expiry pulse (registered)
//
// Optional feature (macro MULTI_DOWN_TIMER_READBACK_EN)
//   rd_ch        channel to read back
//   count_out    count of channel rd_ch, registered, 0 when rd_ch out of range
// -----------------------------------------------------------------------------
module multi_down_timer #(
  parameter int N        = 10,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                ld,
  input  logic [CW-1:0]       ld_ch,
  input  logic                ld_periodic,
  input  logic [N-1:0]        data_in,
  input  logic [CHANNELS-1:0] stop,
  input  logic [CHANNELS-1:0] ack,
`ifdef MULTI_DOWN_TIMER_READBACK_EN
  input  logic [CW-1:0]       rd_ch,
  output logic [N-1:0]        count_out,
`endif
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done,
  output logic [CHANNELS-1:0] expire
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [PW-1:0]       pcnt_q, pcnt_d;
  logic                tick;

  state_t              state_q  [CHANNELS];
  state_t              state_d  [CHANNELS];
  logic [N-1:0]        count_q  [CHANNELS];
  logic [N-1:0]        count_d  [CHANNELS];
  logic [N-1:0]        reload_q [CHANNELS];
  logic [N-1:0]        reload_d [CHANNELS];
  logic [CHANNELS-1:0] mode_q, mode_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] expire_q, expire_d;
  logic [CHANNELS-1:0] busy_q, busy_d;

  // Shared tick: every PRESCALE-th enabled cycle (every enabled cycle when PRESCALE is 1).
  assign tick = en & (pcnt_q == PMAX);

  // Prescaler next value: advances only while en is high, wraps at PRESCALE-1.
  always_comb begin
    pcnt_d = pcnt_q;
    if (en) begin
      if (pcnt_q == PMAX) begin
        pcnt_d = {PW{1'b0}};
      end else begin
        pcnt_d = pcnt_q + PW'(1'b1);
      end
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Per-channel next state. Priority: load > stop > tick.
  always_comb begin
    for (int ch = 0; ch < CHANNELS; ch++) begin
      state_d[ch]  = state_q[ch];
      count_d[ch]  = count_q[ch];
      reload_d[ch] = reload_q[ch];
      mode_d[ch]   = mode_q[ch];
      // Expiry below overrides this clear, so a coincident ack loses to the set.
      done_d[ch]   = done_q[ch] & ~ack[ch];
      expire_d[ch] = 1'b0;

      // An out-of-range ld_ch never equals a real channel index, so it is ignored.
      if (ld && (ld_ch == CW'(ch))) begin
        count_d[ch]  = data_in;
        reload_d[ch] = data_in;
        mode_d[ch]   = ld_periodic;
        done_d[ch]   = 1'b0;
        state_d[ch]  = ST_RUN;
      end else if (stop[ch] && (state_q[ch] != ST_IDLE)) begin
        state_d[ch]  = ST_IDLE;
      end else begin
        case (state_q[ch])
          ST_RUN: begin
            if (tick) begin
              if (count_q[ch] != {N{1'b0}}) begin
                count_d[ch] = count_q[ch] - N'(1'b1);
              end else begin
                expire_d[ch] = 1'b1;
                done_d[ch]   = 1'b1;
                if (mode_q[ch]) begin
                  count_d[ch] = reload_q[ch];
                end else begin
                  state_d[ch] = ST_DONE;
                end
              end
            end else begin
              count_d[ch] = count_q[ch];
            end
          end
          ST_IDLE: state_d[ch] = ST_IDLE;
          ST_DONE: state_d[ch] = ST_DONE;
          default: state_d[ch] = ST_IDLE;
        endcase
      end

      busy_d[ch] = (state_d[ch] == ST_RUN);
    end
  end

  // State, count and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q   <= {PW{1'b0}};
      mode_q   <= {CHANNELS{1'b0}};
      done_q   <= {CHANNELS{1'b0}};
      expire_q <= {CHANNELS{1'b0}};
      busy_q   <= {CHANNELS{1'b0}};
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]  <= ST_IDLE;
        count_q[ch]  <= {N{1'b0}};
        reload_q[ch] <= {N{1'b0}};
      end
    end else begin
      pcnt_q   <= pcnt_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      expire_q <= expire_d;
      busy_q   <= busy_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]  <= state_d[ch];
        count_q[ch]  <= count_d[ch];
        reload_q[ch] <= reload_d[ch];
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign expire = expire_q;

`ifdef MULTI_DOWN_TIMER_READBACK_EN
  logic [N-1:0] count_out_q, count_out_d;

  // Readback mux: selects a channel count, zero when rd_ch names no channel.
  always_comb begin
    count_out_d = {N{1'b0}};
    for (int ch = 0; ch < CHANNELS; ch++) begin
      if (rd_ch == CW'(ch)) begin
        count_out_d = count_q[ch];
      end else begin
        count_out_d = count_out_d;
      end
    end
  end

  // Readback register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_out_q <= {N{1'b0}};
    end else begin
      count_out_q <= count_out_d;
    end
  end

  assign count_out = count_out_q;
`else
  // Readback disabled: no rd_ch / count_out ports or logic.
`endif

endmodule

// File: tb/tb_multi_down_timer.sv
module tb_multi_down_timer;

  // DUT A: 4 channels, PRESCALE 1. DUT B: 3 channels, PRESCALE 4 (ld_ch 3 is out of range).
  localparam int N = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic [1:0] ld_ch = 2'd0;
  logic       ld_periodic = 1'b0;
  logic [N-1:0] data_in = '0;
  logic [3:0] stop = 4'd0;
  logic [3:0] ack = 4'd0;
  logic [3:0] busy_a, done_a, expire_a;
  logic [2:0] busy_b, done_b, expire_b;

  int checks = 0;
  int errors = 0;

  // Reference model: per channel, ticks remaining until expiry.
  int  m_left [2][4];
  int  m_rel  [2][4];
  bit  m_run  [2][4];
  bit  m_per  [2][4];
  bit  m_done [2][4];
  bit  m_exp  [2][4];
  int  en_total [2];
  logic [11:0] exp_a = '0;
  logic [8:0]  exp_b = '0;

  always #5 clk = ~clk;

  multi_down_timer #(.N(N), .CHANNELS(4), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .ld(ld), .ld_ch(ld_ch),
    .ld_periodic(ld_periodic), .data_in(data_in), .stop(stop), .ack(ack),
    .busy(busy_a), .done(done_a), .expire(expire_a)
  );

  multi_down_timer #(.N(N), .CHANNELS(3), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .ld(ld), .ld_ch(ld_ch),
    .ld_periodic(ld_periodic), .data_in(data_in), .stop(stop[2:0]), .ack(ack[2:0]),
    .busy(busy_b), .done(done_b), .expire(expire_b)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      en_total[d] = 0;
      for (int c = 0; c < 4; c++) begin
        m_left[d][c] = 0; m_rel[d][c] = 0; m_run[d][c] = 0;
        m_per[d][c] = 0; m_done[d][c] = 0; m_exp[d][c] = 0;
      end
    end
    exp_a = '0;
    exp_b = '0;
  endtask

  // One clock of the model using the inputs the DUT is about to sample.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int p   = (d == 0) ? 1 : 4;
      int nch = (d == 0) ? 4 : 3;
      bit tk  = en && ((en_total[d] % p) == p - 1);
      if (en) en_total[d]++;
      for (int c = 0; c < nch; c++) begin
        m_exp[d][c] = 0;
        if (ld && (int'(ld_ch) == c)) begin
          m_left[d][c] = int'(data_in) + 1;
          m_rel[d][c]  = int'(data_in);
          m_per[d][c]  = ld_periodic;
          m_done[d][c] = 0;
          m_run[d][c]  = 1;
        end else begin
          if (ack[c]) m_done[d][c] = 0;
          if (stop[c]) begin
            m_run[d][c] = 0;
          end else if (m_run[d][c] && tk) begin
            m_left[d][c]--;
            if (m_left[d][c] == 0) begin
              m_exp[d][c]  = 1;
              m_done[d][c] = 1;
              if (m_per[d][c]) m_left[d][c] = m_rel[d][c] + 1;
              else m_run[d][c] = 0;
            end
          end
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      exp_a[8 + c] = m_run[0][c];
      exp_a[4 + c] = m_done[0][c];
      exp_a[c]     = m_exp[0][c];
    end
    for (int c = 0; c < 3; c++) begin
      exp_b[6 + c] = m_run[1][c];
      exp_b[3 + c] = m_done[1][c];
      exp_b[c]     = m_exp[1][c];
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({busy_a, done_a, expire_a} !== 12'd0) begin
      errors++; $display("FAIL reset_a got %h want 000", {busy_a, done_a, expire_a});
    end
    checks++;
    if ({busy_b, done_b, expire_b} !== 9'd0) begin
      errors++; $display("FAIL reset_b got %h want 000", {busy_b, done_b, expire_b});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_oneshot();
    int first = 0;
    apply_reset();
    en = 1'b1; ld_ch = 2'd0; data_in = 10'd3; ld_periodic = 1'b0; ld = 1'b1;
    advance();
    ld = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      advance();
      checks++;
      if ({busy_a, done_a, expire_a} !== exp_a) begin
        errors++; $display("FAIL oneshot_a k=%0d got %h want %h", k, {busy_a, done_a, expire_a}, exp_a);
      end
      checks++;
      if ({busy_b, done_b, expire_b} !== exp_b) begin
        errors++; $display("FAIL oneshot_b k=%0d got %h want %h", k, {busy_b, done_b, expire_b}, exp_b);
      end
      if (expire_a[0] && first == 0) first = k;
    end
    checks++;
    if (first != 4) begin
      errors++; $display("FAIL oneshot_latency got %0d want 4", first);
    end
    checks++;
    if ({done_a, busy_a} !== 8'b0001_0000) begin
      errors++; $display("FAIL oneshot_final got %b want 00010000", {done_a, busy_a});
    end
  endtask

  task automatic test_periodic();
    int pulses = 0;
    int busy_miss = 0;
    ld_ch = 2'd1; data_in = 10'd2; ld_periodic = 1'b1; ld = 1'b1;
    advance();
    ld = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      advance();
      checks++;
      if ({busy_a, done_a, expire_a} !== exp_a) begin
        errors++; $display("FAIL periodic_a k=%0d got %h want %h", k, {busy_a, done_a, expire_a}, exp_a);
      end
      if (expire_a[1]) pulses++;
      if (!busy_a[1]) busy_miss++;
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL periodic_pulses got %0d want 4", pulses);
    end
    checks++;
    if (busy_miss != 0) begin
      errors++; $display("FAIL periodic_busy got %0d idle cycles want 0", busy_miss);
    end
  endtask

  task automatic test_prescale();
    int c1 = 0;
    int c2 = 0;
    for (int run = 0; run < 2; run++) begin
      apply_reset();
      en = 1'b0; ld_ch = 2'd2; data_in = 10'd1; ld_periodic = 1'b0; ld = 1'b1;
      advance();
      ld = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        en = (run == 1 && k > 3 && k <= 8) ? 1'b0 : 1'b1;
        advance();
        checks++;
        if ({busy_b, done_b, expire_b} !== exp_b) begin
          errors++; $display("FAIL prescale_b run=%0d k=%0d got %h want %h", run, k, {busy_b, done_b, expire_b}, exp_b);
        end
        if (expire_b[2] && run == 0 && c1 == 0) c1 = k;
        if (expire_b[2] && run == 1 && c2 == 0) c2 = k;
      end
    end
    en = 1'b1;
    checks++;
    if (c1 != 8) begin
      errors++; $display("FAIL prescale_latency got %0d want 8", c1);
    end
    checks++;
    if (c2 != 13) begin
      errors++; $display("FAIL prescale_pause got %0d want 13", c2);
    end
  endtask

  task automatic test_stop_reload();
    int stray = 0;
    en = 1'b1; ld_ch = 2'd3; data_in = 10'd5; ld_periodic = 1'b0; ld = 1'b1;
    advance();
    ld = 1'b0;
    advance();
    advance();
    stop = 4'b1000;
    advance();
    stop = 4'd0;
    checks++;
    if ({busy_a[3], done_a[3]} !== 2'b00) begin
      errors++; $display("FAIL stop_state got %b want 00", {busy_a[3], done_a[3]});
    end
    for (int k = 0; k < 8; k++) begin
      advance();
      if (expire_a[3]) stray++;
      checks++;
      if ({busy_a, done_a, expire_a} !== exp_a) begin
        errors++; $display("FAIL stop_model k=%0d got %h want %h", k, {busy_a, done_a, expire_a}, exp_a);
      end
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL stop_expire got %0d pulses want 0", stray);
    end
    data_in = 10'd0; ld = 1'b1;
    advance();
    ld = 1'b0;
    advance();
    checks++;
    if (expire_a[3] !== 1'b1) begin
      errors++; $display("FAIL reload_zero got %b want 1", expire_a[3]);
    end
  endtask

  task automatic test_ack();
    en = 1'b1; ld_ch = 2'd0; data_in = 10'd0; ld_periodic = 1'b1; ld = 1'b1;
    advance();
    ld = 1'b0;
    advance();
    ack = 4'b0001;
    advance();
    ack = 4'd0;
    checks++;
    if ({expire_a[0], done_a[0]} !== 2'b11) begin
      errors++; $display("FAIL ack_on_expiry got %b want 11", {expire_a[0], done_a[0]});
    end
    en = 1'b0; ack = 4'b0001;
    advance();
    ack = 4'd0;
    checks++;
    if (done_a[0] !== 1'b0) begin
      errors++; $display("FAIL ack_clear got %b want 0", done_a[0]);
    end
    checks++;
    if ({busy_a, done_a, expire_a} !== exp_a) begin
      errors++; $display("FAIL ack_model got %h want %h", {busy_a, done_a, expire_a}, exp_a);
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    en = 1'b1; ld_periodic = 1'b0; data_in = 10'd20;
    for (int c = 0; c < 4; c++) begin
      ld_ch = 2'(c); ld = 1'b1;
      advance();
    end
    ld = 1'b0;
    advance();
    checks++;
    if (busy_a !== 4'hf) begin
      errors++; $display("FAIL pre_reset_busy got %b want 1111", busy_a);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy_a, done_a, expire_a} !== 12'd0) begin
      errors++; $display("FAIL async_reset_a got %h want 000", {busy_a, done_a, expire_a});
    end
    checks++;
    if ({busy_b, done_b, expire_b} !== 9'd0) begin
      errors++; $display("FAIL async_reset_b got %h want 000", {busy_b, done_b, expire_b});
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ld_ch = 2'd3; data_in = 10'd7; ld = 1'b1;
    advance();
    ld = 1'b0;
    advance();
    checks++;
    if ({busy_b, done_b, expire_b} !== 9'd0) begin
      errors++; $display("FAIL out_of_range_ld got %h want 000", {busy_b, done_b, expire_b});
    end
    checks++;
    if ({busy_a, done_a, expire_a} !== exp_a) begin
      errors++; $display("FAIL out_of_range_a got %h want %h", {busy_a, done_a, expire_a}, exp_a);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en          = ($urandom_range(0, 3) != 0);
      ld          = ($urandom_range(0, 7) == 0);
      ld_ch       = 2'($urandom_range(0, 3));
      ld_periodic = 1'($urandom_range(0, 1));
      data_in     = 10'($urandom_range(0, 6));
      stop        = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      ack         = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      advance();
      checks++;
      if ({busy_a, done_a, expire_a} !== exp_a) begin
        errors++; $display("FAIL random_a k=%0d got %h want %h", k, {busy_a, done_a, expire_a}, exp_a);
      end
      checks++;
      if ({busy_b, done_b, expire_b} !== exp_b) begin
        errors++; $display("FAIL random_b k=%0d got %h want %h", k, {busy_b, done_b, expire_b}, exp_b);
      end
    end
    ld = 1'b0; stop = 4'd0; ack = 4'd0;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_prescale();
    test_stop_reload();
    test_ack();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_down_timer.md
Name: multi_down_timer

Overview:
- Multi-channel successor to the single down counter.
- CHANNELS independent N-bit down-timers share a global prescaled tick.
- Each channel runs in one-shot or periodic (auto-reload) mode, with a sticky done flag, a one-cycle expire pulse, abort (stop) and acknowledge.
- Used by game logic for duck flight windows, shot timeouts and frame-rate periodic events.

Parameters:
- N, 10: counter/load width per channel.
- CHANNELS, 4: number of timer channels (1..16).
- PRESCALE, 1: clk-enables per timer tick (1..65535); 1 means every en cycle is a tick.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global count enable, feeds the prescaler.
- ld  in  1  load strobe for channel ld_ch.
- ld_ch  in  CW  target channel; CW = max(1,$clog2(CHANNELS)).
- ld_periodic  in  1  mode latched on load: 1 = periodic, 0 = one-shot.
- data_in  in  N  load/reload value.
- stop  in  CHANNELS  per-channel abort.
- ack  in  CHANNELS  per-channel done clear.
- busy  out  CHANNELS  channel in RUN.
- done  out  CHANNELS  sticky expiry flag.
- expire  out  CHANNELS  one-cycle pulse per expiry.

Behaviour:
- Reset (async, active-high):
  - All counts, reload regs, mode bits and the prescaler clear to 0.
  - All states go to IDLE.
  - busy, done, expire = 0.
- Prescaler:
  - pcnt increments on en and wraps at PRESCALE-1.
  - tick = en & (pcnt == PRESCALE-1), combinational, shared by all channels.
  - PRESCALE=1: tick = en.
  - en low freezes pcnt.
- Per-channel FSM has states IDLE, RUN, DONE. Priority per channel: ld (when ld_ch == ch) > stop > tick.
- ld:
  - count <= data_in; reload <= data_in; mode <= ld_periodic.
  - done <= 0; state <= RUN. Legal from any state.
- stop in RUN or DONE: state <= IDLE; count is held; done is unchanged.
- RUN & tick & count != 0: count <= count-1.
- RUN & tick & count == 0:
  - expire <= 1 for exactly one cycle.
  - done <= 1.
  - one-shot: state <= DONE.
  - periodic: count <= reload; stays in RUN.
- Latency: load value V gives expiry on the (V+1)th tick after load. expire and done are registered, so visible the cycle after that tick.
- Periodic period = V+1 ticks. V=0 gives expire on every tick.
- ack clears done. If expiry and ack coincide, the set wins (done stays 1).
- ld_ch >= CHANNELS: load ignored, no channel affected.
- Loads to one channel never disturb other channels or the prescaler.
- Tick and ld in the same cycle on the same channel: load wins, no decrement.
- busy = (state == RUN), registered.
- Reset mid-count: immediate clear, no expire pulse emitted.

Optional Feature:
- Macro: MULTI_DOWN_TIMER_READBACK_EN.
- Defined: adds input rd_ch [CW] and output count_out [N]. count_out is the registered count of channel rd_ch, one-cycle latency; out-of-range rd_ch gives 0; reset value 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- PRESCALE=1, en=1; load ch0 V=3 one-shot -> expire[0] pulses 4 cycles after ld cycle +1; done[0]=1 and busy[0]=0 thereafter; others stay 0.
- Load ch1 V=2 periodic, en=1 for 12 cycles -> expire[1] pulses every 3 cycles (4 pulses); busy[1] stays 1.
- PRESCALE=4; load ch2 V=1 -> expire[2] after 8 en cycles. Hold en low 5 cycles mid-count -> expiry delayed by exactly 5 cycles.
- ld ch3 V=5 with tick on the same cycle, then stop[3] after 2 ticks -> busy[3] drops, no expire, done[3]=0. Reload V=0 -> expire on next tick.
- Periodic ch0 V=0 with ack[0] asserted on an expiry cycle -> done[0] remains 1. ack on a non-expiry cycle -> done[0]=0.
- Assert reset asynchronously mid-count on all channels -> busy/done/expire=0 immediately. ld_ch=CHANNELS load -> no output change.
